// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the i2c request arbiter.
// FSM state encoding, arbiter error status codes, request field widths.
package i2c_arb_pkg;

    localparam int CHIP_W = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 16;

    localparam logic [3:0] STATUS_NOSTART = 4'hE;
    localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester and i2c-master request bundle.
// slave = arbiter view, master = requesters plus i2c master view.
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import i2c_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [CHIP_W*NUM_REQ-1:0] req_chip_addr;
    logic [REG_W*NUM_REQ-1:0]  req_reg_addr;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic [3:0]                resp_status;
    logic                      arb_busy;
    logic [CHIP_W-1:0]         m_chip_addr;
    logic [REG_W-1:0]          m_reg_addr;
    logic [DATA_W-1:0]         m_data_in;
    logic                      m_write_en;
    logic                      m_read_en;
    logic                      m_busy;
    logic [DATA_W-1:0]         m_data_out;
    logic [3:0]                m_status;

    modport slave (
        input  req_valid, req_write, req_chip_addr, req_reg_addr, req_data,
        input  m_busy, m_data_out, m_status,
        output req_ack, resp_valid, resp_data, resp_status, arb_busy,
        output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
    );

    modport master (
        output req_valid, req_write, req_chip_addr, req_reg_addr, req_data,
        output m_busy, m_data_out, m_status,
        input  req_ack, resp_valid, resp_data, resp_status, arb_busy,
        input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
    );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: combinational round-robin pick, first set bit at/after ptr_i.
// Ports: req_i, ptr_i in; gnt_o (one-hot), idx_o (binary), vld_o out.
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               vld_o
);

    logic [IW:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // wrap without a modulo so NUM_REQ need not be a power of two
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ))
                pos = pos - (IW+1)'(NUM_REQ);
            if (!vld_o && req_i[pos[IW-1:0]]) begin
                vld_o               = 1'b1;
                gnt_o[pos[IW-1:0]] = 1'b1;
                idx_o               = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one i2c master among NUM_REQ requesters, round-robin.
// Ports: clk, reset (async, active-low), bus (slave modport). Option: I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int START_WAIT     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic               clk,
    input logic               reset,
    i2c_req_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(START_WAIT + 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic                 wr_q, wr_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   rv_q, rv_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [3:0]           rstat_q, rstat_d;
    logic [CHIP_W-1:0]    chip_q, chip_d;
    logic [REG_W-1:0]     reg_q, reg_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 wen_q, wen_d;
    logic                 ren_q, ren_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic                 start_last;

    assign start_last = (scnt_q == SW'(START_WAIT - 1));

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        wd_last;
    assign wd_last = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = |32'(TIMEOUT_CYCLES);
`endif

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .vld_o   (gnt_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            wr_q    <= 1'b0;
            scnt_q  <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            rdata_q <= '0;
            rstat_q <= '0;
            chip_q  <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            wr_q    <= wr_d;
            scnt_q  <= scnt_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            rstat_q <= rstat_d;
            chip_q  <= chip_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (gnt_vld) state_d = ST_ISSUE;
            ST_ISSUE:      state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (bus.m_busy)      state_d = ST_WAIT_DONE;
                else if (start_last) state_d = ST_RESP;
            end
            ST_WAIT_DONE: begin
                if (!bus.m_busy) state_d = ST_RESP;
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_last) state_d = ST_RESP;
`endif
            end
            ST_RESP:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_d   = '0;
        rv_d    = '0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        gidx_d  = gidx_q;
        wr_d    = wr_q;
        chip_d  = chip_q;
        reg_d   = reg_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        rstat_d = rstat_q;
        scnt_d  = scnt_q;
        ptr_d   = ptr_q;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    ack_d  = gnt;
                    gidx_d = gnt_idx;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (gnt[k]) begin
                            wr_d   = bus.req_write[k];
                            chip_d = bus.req_chip_addr[k*CHIP_W +: CHIP_W];
                            reg_d  = bus.req_reg_addr[k*REG_W +: REG_W];
                            data_d = bus.req_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                wen_d  = wr_q;
                ren_d  = ~wr_q;
                scnt_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d   = '0;
`endif
            end
            ST_WAIT_START: begin
                if (!bus.m_busy) begin
                    if (start_last) begin
                        rstat_d = STATUS_NOSTART;
                        rdata_d = '0;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.m_busy) begin
                    rdata_d = bus.m_data_out;
                    rstat_d = bus.m_status;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_last) begin
                    rstat_d = STATUS_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
            end
            default: ;
        endcase
        // registered so the pulse lines up with the RESP cycle
        if (state_d == ST_RESP)
            rv_d[gidx_q] = 1'b1;
    end

    assign bus.req_ack     = ack_q;
    assign bus.resp_valid  = rv_q;
    assign bus.resp_data   = rdata_q;
    assign bus.resp_status = rstat_q;
    assign bus.arb_busy    = (state_q != ST_IDLE);
    assign bus.m_chip_addr = chip_q;
    assign bus.m_reg_addr  = reg_q;
    assign bus.m_data_in   = data_q;
    assign bus.m_write_en  = wen_q;
    assign bus.m_read_en   = ren_q;

endmodule
